// File: rtl/rv_sim_ctrl.sv
// Test controller for the RV core benches: sequences core reset, counts RUN
// cycles and retired instructions, and ends the test on a tohost write or watchdog.
module rv_sim_ctrl #(
    parameter int unsigned           ADDR_W       = 32,
    parameter int unsigned           DATA_W       = 32,
    parameter int unsigned           CNT_W        = 32,
    parameter int unsigned           RESET_CYCLES = 4,
    parameter int unsigned           MAX_CYCLES   = 1000,
    parameter logic [ADDR_W-1:0]     TOHOST_ADDR  = 32'h8000_1000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                core_rst,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                retire,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret_cnt,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [DATA_W-2:0]   fail_code
);

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam int unsigned       HOLD_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DATA_W-1:0] PASS_WORD = DATA_W'(1);

    logic [2:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hit;
    logic [CNT_W-1:0]  cycle_inc;
    logic [CNT_W-1:0]  instret_inc;

    always_comb begin
        hit         = mem_we & (mem_addr == TOHOST_ADDR) & mem_wdata[0];
        cycle_inc   = (cycle_cnt == '1)   ? cycle_cnt   : cycle_cnt + CNT_W'(1);
        instret_inc = (instret_cnt == '1) ? instret_cnt : instret_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            fail_code   <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST)
                        state <= S_RUN;
                    else
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                S_RUN: begin
                    // The ending cycle itself is counted, so counters update before the exit decision lands.
                    cycle_cnt <= cycle_inc;
                    if (retire)
                        instret_cnt <= instret_inc;
                    if (hit) begin
                        if (mem_wdata == PASS_WORD) begin
                            state <= S_PASS;
                        end else begin
                            state     <= S_FAIL;
                            fail_code <= mem_wdata[DATA_W-1:1];
                        end
                    end else if (cycle_cnt == WDOG_LAST) begin
                        state <= S_TIMEOUT;
                    end
                end
                S_PASS, S_FAIL, S_TIMEOUT: ;
                default: state <= S_HOLD;
            endcase
        end
    end

    // Flags decode straight from the state register, so they carry no input-to-output path.
    assign core_rst = (state != S_RUN);
    assign pass     = (state == S_PASS);
    assign fail     = (state == S_FAIL);
    assign timeout  = (state == S_TIMEOUT);
    assign done     = pass | fail | timeout;

endmodule

// File: tb/tb_rv_sim_ctrl.sv
// Scoreboard bench for rv_sim_ctrl: stimulus queues expected end-of-test records,
// a negedge monitor pops one whenever done rises and compares all result fields.
module tb_rv_sim_ctrl;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic        clk;
    logic        rst;
    logic        core_rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        retire;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_code;

    rv_sim_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .CNT_W        (32),
        .RESET_CYCLES (4),
        .MAX_CYCLES   (20),
        .TOHOST_ADDR  (32'h8000_1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_rst    (core_rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code)
    );

    typedef struct {
        bit          p;
        bit          f;
        bit          t;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [30:0] code;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_q   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
    endtask

    task automatic push(input bit p, input bit f, input bit t,
                        input logic [31:0] cyc, input logic [31:0] ins, input logic [30:0] code);
        exp_t e;
        e.p = p; e.f = f; e.t = t; e.cyc = cyc; e.ins = ins; e.code = code;
        q.push_back(e);
    endtask

    // Monitor: one record per rising done.
    always @(negedge clk) begin
        if (!rst && done && !done_q) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no end (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pass",     pass,        e.p);
                chk("sb_fail",     fail,        e.f);
                chk("sb_timeout",  timeout,     e.t);
                chk("sb_cycle",    cycle_cnt,   e.cyc);
                chk("sb_instret",  instret_cnt, e.ins);
                chk("sb_failcode", fail_code,   e.code);
                chk("sb_core_rst", core_rst,    1'b1);
            end
        end
        done_q = done;
    end

    // Reset for three cycles, then walk the hold phase; returns in RUN cycle 1.
    // With noise set, a tohost pass write and retires are driven throughout the hold.
    task automatic run_to_run(input bit noise);
        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_done",     done,     1'b0);
        chk("rst_flags",    {pass, fail, timeout}, 3'b000);
        chk("rst_cycle",    cycle_cnt,   0);
        chk("rst_instret",  instret_cnt, 0);
        chk("rst_failcode", fail_code,   0);
        if (noise) begin
            mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1; retire = 1'b1;
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("hold_core_rst", core_rst,  1'b1);
            chk("hold_cycle",    cycle_cnt, 0);
            chk("hold_done",     done,      1'b0);
        end
        tick();
        idle();
        chk("run_core_rst", core_rst,    1'b0);
        chk("run_cycle0",   cycle_cnt,   0);
        chk("run_instret0", instret_cnt, 0);
        chk("run_done0",    done,        1'b0);
    endtask

    task automatic t2_pass();
        for (int k = 1; k <= 10; k++) begin
            retire = (k <= 5);
            if (k == 10) begin
                mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1;
                push(1'b1, 1'b0, 1'b0, 32'd10, 32'd5, 31'd0);
            end
            tick();
            idle();
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // T1 + T2
        run_to_run(1'b0);
        t2_pass();
        chk("t2_hold_done", done, 1'b1);

        // T3: fail code, then frozen
        run_to_run(1'b0);
        for (int k = 1; k <= 3; k++) begin
            retire = (k == 2);
            if (k == 3) begin
                mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h0000_0007;
                push(1'b0, 1'b1, 1'b0, 32'd3, 32'd1, 31'd3);
            end
            tick();
            idle();
        end
        mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1; retire = 1'b1;
        repeat (3) tick();
        idle();
        chk("t3_late_pass",  pass,        1'b0);
        chk("t3_late_fail",  fail,        1'b1);
        chk("t3_late_cycle", cycle_cnt,   3);
        chk("t3_late_inst",  instret_cnt, 1);
        chk("t3_late_code",  fail_code,   3);

        // T4 filters (incl. hold-phase write) then T5 watchdog
        run_to_run(1'b1);
        for (int k = 1; k <= 20; k++) begin
            retire = (k <= 3);
            case (k)
                1: begin mem_we = 1'b1; mem_addr = TOHOST;         mem_wdata = 32'd2; end
                2: begin mem_we = 1'b1; mem_addr = TOHOST + 32'd4; mem_wdata = 32'd1; end
                3: begin mem_we = 1'b0; mem_addr = TOHOST;         mem_wdata = 32'd1; end
                default: ;
            endcase
            if (k == 20) push(1'b0, 1'b0, 1'b1, 32'd20, 32'd3, 31'd0);
            tick();
            idle();
            if (k == 5) begin
                chk("t4_done",    done,        1'b0);
                chk("t4_cycle",   cycle_cnt,   5);
                chk("t4_instret", instret_cnt, 3);
            end
            if (k == 19) chk("t5_pre_done", done, 1'b0);
        end
        repeat (3) tick();
        chk("t5_frozen_cycle", cycle_cnt, 20);

        // T5b: hit and watchdog in the same cycle
        run_to_run(1'b0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) begin
                mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1;
                push(1'b1, 1'b0, 1'b0, 32'd20, 32'd0, 31'd0);
            end
            tick();
            idle();
        end
        tick();

        // T6: reset at RUN cycle 7, then rerun T2
        run_to_run(1'b0);
        for (int k = 1; k <= 6; k++) begin
            retire = k[0];
            tick();
            idle();
        end
        chk("t6_cycle_before", cycle_cnt,   6);
        chk("t6_inst_before",  instret_cnt, 3);
        run_to_run(1'b0);
        t2_pass();

        repeat (3) tick();
        chk("sb_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
